// File: rtl/rgen_host_arbiter_pkg.sv
// Shared status codes and FSM state type for the host arbiter.
package rgen_host_arbiter_pkg;

  localparam logic [1:0] STATUS_OKAY        = 2'b00;
  localparam logic [1:0] STATUS_SLAVE_ERROR = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT     = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/rgen_host_arbiter_if.sv
// Host-side request bundle plus register-block command port of the arbiter.
interface rgen_host_arbiter_if #(
  parameter int HOSTS         = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);

  logic [HOSTS-1:0]               i_host_request;
  logic [HOSTS-1:0]               i_host_write;
  logic [HOSTS*ADDRESS_WIDTH-1:0] i_host_address;
  logic [HOSTS*DATA_WIDTH-1:0]    i_host_write_data;
  logic [HOSTS*DATA_WIDTH-1:0]    i_host_write_mask;
  logic [HOSTS-1:0]               o_host_ack;
  logic [DATA_WIDTH-1:0]          o_host_read_data;
  logic [1:0]                     o_host_status;

  logic                           o_command_valid;
  logic                           o_write;
  logic [ADDRESS_WIDTH-1:0]       o_address;
  logic [DATA_WIDTH-1:0]          o_write_data;
  logic [DATA_WIDTH-1:0]          o_write_mask;
  logic                           i_response_ready;
  logic [DATA_WIDTH-1:0]          i_read_data;
  logic [1:0]                     i_status;

  // master: the arbiter itself; slave: host bridges and register block
  modport master (
    input  i_host_request, i_host_write, i_host_address, i_host_write_data, i_host_write_mask,
    output o_host_ack, o_host_read_data, o_host_status,
    output o_command_valid, o_write, o_address, o_write_data, o_write_mask,
    input  i_response_ready, i_read_data, i_status
  );

  modport slave (
    output i_host_request, i_host_write, i_host_address, i_host_write_data, i_host_write_mask,
    input  o_host_ack, o_host_read_data, o_host_status,
    input  o_command_valid, o_write, o_address, o_write_data, o_write_mask,
    output i_response_ready, i_read_data, i_status
  );

endinterface

// File: rtl/rgen_round_robin_arbiter.sv
// Round-robin picker: grants the first requester after the last-granted host.
module rgen_round_robin_arbiter #(
  parameter  int HOSTS = 2,
  localparam int PW    = (HOSTS > 1) ? $clog2(HOSTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [HOSTS-1:0] request,
  input  logic             update,
  output logic [HOSTS-1:0] grant
);

  logic [PW-1:0] last_ptr;
  logic [PW-1:0] next_ptr;
  logic          found;

  always_comb begin
    grant    = '0;
    next_ptr = last_ptr;
    found    = 1'b0;
    for (int i = 1; i <= HOSTS; i++) begin
      for (int h = 0; h < HOSTS; h++) begin
        if (!found && request[h] && (h == (int'(last_ptr) + i) % HOSTS)) begin
          found    = 1'b1;
          grant[h] = 1'b1;
          next_ptr = PW'(h);
        end
      end
    end
  end

  // Reset points at the highest host so host 0 wins the first arbitration
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ptr <= PW'(HOSTS - 1);
    end else if (update && found) begin
      last_ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/rgen_host_arbiter.sv
// Shares the register block command port between HOSTS requesters with a
// per-command response timeout.
//
//   state   | meaning
//   IDLE    | waiting for any host request; arbitrates and latches the command
//   BUSY    | command presented; waiting for response or timeout
//   RESPOND | one-cycle ack with read data/status to the granted host
module rgen_host_arbiter
  import rgen_host_arbiter_pkg::*;
#(
  parameter int HOSTS         = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 64
) (
  input logic                clk,
  input logic                rst,
  rgen_host_arbiter_if.master bus
);

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                   state;
  logic [HOSTS-1:0]         grant;
  logic [HOSTS-1:0]         grant_q;
  logic [CW-1:0]            count;
  logic                     sel_write;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [DATA_WIDTH-1:0]    sel_write_data;
  logic [DATA_WIDTH-1:0]    sel_write_mask;

  rgen_round_robin_arbiter #(.HOSTS(HOSTS)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .request (bus.i_host_request),
    .update  (state == IDLE),
    .grant   (grant)
  );

  // One-hot grant makes an OR-reduction mux sufficient
  always_comb begin
    sel_write      = 1'b0;
    sel_address    = '0;
    sel_write_data = '0;
    sel_write_mask = '0;
    for (int h = 0; h < HOSTS; h++) begin
      if (grant[h]) begin
        sel_write      |= bus.i_host_write[h];
        sel_address    |= bus.i_host_address[h*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_write_data |= bus.i_host_write_data[h*DATA_WIDTH +: DATA_WIDTH];
        sel_write_mask |= bus.i_host_write_mask[h*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      grant_q              <= '0;
      count                <= '0;
      bus.o_command_valid  <= 1'b0;
      bus.o_write          <= 1'b0;
      bus.o_address        <= '0;
      bus.o_write_data     <= '0;
      bus.o_write_mask     <= '0;
      bus.o_host_ack       <= '0;
      bus.o_host_read_data <= '0;
      bus.o_host_status    <= '0;
    end else begin
      bus.o_host_ack       <= '0;
      bus.o_host_read_data <= '0;
      bus.o_host_status    <= '0;
      case (state)
        IDLE: begin
          if (|bus.i_host_request) begin
            grant_q             <= grant;
            bus.o_write         <= sel_write;
            bus.o_address       <= sel_address;
            bus.o_write_data    <= sel_write_data;
            bus.o_write_mask    <= sel_write_mask;
            bus.o_command_valid <= 1'b1;
            count               <= '0;
            state               <= BUSY;
          end
        end
        BUSY: begin
          // A response in the expiry cycle takes priority over the timeout
          if (bus.i_response_ready) begin
            bus.o_host_ack       <= grant_q;
            bus.o_host_read_data <= bus.o_write ? '0 : bus.i_read_data;
            bus.o_host_status    <= bus.i_status;
            bus.o_command_valid  <= 1'b0;
            count                <= '0;
            state                <= RESPOND;
          end else if ((TIMEOUT != 0) && (count == CNT_LAST)) begin
            bus.o_host_ack       <= grant_q;
            bus.o_host_status    <= STATUS_TIMEOUT;
            bus.o_command_valid  <= 1'b0;
            count                <= '0;
            state                <= RESPOND;
          end else if (count != '1) begin
            count <= count + CW'(1);
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
